// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath.
// Serial add/sub controller states and operation encodings.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : calc_pkg

// File: rtl/full_adder.sv
// One-bit full adder: the whole arithmetic datapath of the serial add/sub unit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder sequenced LSB first over
// WIDTH cycles, with start/ready operand loading and valid/ack result delivery.
module serial_adder_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    serial_state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-2:0] res_sh_reg;
    logic             carry_reg;

    logic [WIDTH-1:0] b_cond;
    logic [WIDTH-1:0] res_next;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    // Subtraction is A + ~B + 1: B is inverted here, the +1 enters as carry-in.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_cond
            assign b_cond[gi] = b_i[gi] ^ (sub_i == OP_SUB);
        end
    endgenerate

    full_adder u_full_adder (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_reg == CNT_LAST);
    // Partial result holds only the WIDTH-1 bits already produced, so the
    // final assembled word includes the bit coming out of the adder this cycle.
    assign res_next = {fa_sum, res_sh_reg};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i)  state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (ack_i)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state_reg)
            IDLE:    ready_o = 1'b1;
            RUN:     busy_o  = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            sum_o      <= '0;
            cout_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        a_sh_reg  <= a_i;
                        b_sh_reg  <= b_cond;
                        carry_reg <= sub_i;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    carry_reg  <= fa_cout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    res_sh_reg <= res_next[WIDTH-1:1];
                    // Result outputs change only on the edge that enters DONE.
                    if (last_bit) begin
                        sum_o  <= res_next;
                        cout_o <= fa_cout;
                        ovf_o  <= carry_reg ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         ack = 1'b0;
    logic         ready_o, busy_o, valid_o, cout_o, ovf_o;
    logic [W-1:0] sum_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   rise_cyc[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .sub_i   (sub),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .ack_i   (ack),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int av, input int bv, input bit s);
        exp_t r;
        int   t, sa, sb, sr;
        t  = s ? av + (255 - bv) + 1 : av + bv;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        sr = s ? sa - sb : sa + sb;
        r.sum  = W'(t % 256);
        r.cout = (t >= 256);
        r.ovf  = (sr > 127) || (sr < -128);
        return r;
    endfunction

    // Monitor: pops one expectation per valid_o assertion, checks it every cycle valid_o is held.
    initial begin
        exp_t cur;
        bit   prev_valid;
        bit   cur_ok;
        prev_valid = 1'b0;
        cur_ok = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else if (valid_o === 1'b1) begin
                if (!prev_valid) begin
                    rise_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        cur_ok = 1'b0;
                        $display("FAIL unexpected_valid actual=result required=none (cycle %0d)", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        cur_ok = 1'b1;
                        $display("txn cyc=%0d sum=%02h cout=%0b ovf=%0b exp_sum=%02h exp_cout=%0b exp_ovf=%0b",
                                 cyc, sum_o, cout_o, ovf_o, cur.sum, cur.cout, cur.ovf);
                    end
                end
                if (cur_ok) begin
                    chk("sum", 32'(sum_o), 32'(cur.sum));
                    chk("cout", 32'(cout_o), 32'(cur.cout));
                    chk("ovf", 32'(ovf_o), 32'(cur.ovf));
                end
                prev_valid = 1'b1;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && ready_o !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        if (ready_o !== 1'b1) chk("ready_timeout", 32'(ready_o), 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && valid_o !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        if (valid_o !== 1'b1) chk("valid_timeout", 32'(valid_o), 32'd1);
    endtask

    // Returns #1 after the edge that sampled start.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                            input bit push);
        wait_ready();
        a = av;
        b = bv;
        sub = s;
        if (push) exp_q.push_back(model(int'(av), int'(bv), s));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        chk("ready_after_ack", 32'(ready_o), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                          input int hold);
        start_op(av, bv, s, 1'b1);
        wait_valid();
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        ack_pulse();
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_sum", 32'(sum_o), 32'd0);
        chk("rst_cout", 32'(cout_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);

        // Basic add with cycle-exact timing.
        start_op(8'd23, 8'd42, 1'b0, 1'b1);
        for (int i = 1; i <= W; i++) begin
            chk("run_busy", 32'(busy_o), 32'd1);
            chk("run_valid", 32'(valid_o), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("latency_valid", 32'(valid_o), 32'd1);
        ack_pulse();

        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'd5,  8'd7,  1'b1, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);

        // start during RUN must be ignored.
        start_op(8'd200, 8'd99, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid();
        ack_pulse();

        // ack held off five cycles; monitor checks outputs stay stable.
        run_op(8'h3C, 8'hA5, 1'b1, 5);

        // ack with start in DONE: back to IDLE, no new operation.
        start_op(8'd10, 8'd20, 1'b0, 1'b1);
        wait_valid();
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ack = 1'b0;
        chk("ackstart_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk("ackstart_no_op_ready", 32'(ready_o), 32'd1);
        chk("ackstart_no_op_busy", 32'(busy_o), 32'd0);

        // Back-to-back with ack tied high.
        n0 = rise_cyc.size();
        ack = 1'b1;
        start_op(8'd17, 8'd34, 1'b0, 1'b1);
        start_op(8'd90, 8'd45, 1'b1, 1'b1);
        wait_valid();
        wait_ready();
        ack = 1'b0;
        if (rise_cyc.size() >= n0 + 2)
            chk("b2b_spacing", 32'(rise_cyc[n0+1] - rise_cyc[n0]), 32'd10);
        else
            chk("b2b_count", 32'(rise_cyc.size() - n0), 32'd2);

        // Reset mid-operation aborts it.
        start_op(8'd200, 8'd100, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_sum", 32'(sum_o), 32'd0);
        chk("midrst_cout", 32'(cout_o), 32'd0);
        chk("midrst_ovf", 32'(ovf_o), 32'd0);
        run_op(8'd100, 8'd27, 1'b0, 0);

        // Random operations with random ack delay.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
